// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack arbiter slice.
package stack_pkg;

    localparam int STACK_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP
    } op_t;

    // Width needed to hold an occupancy value in 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest distance from ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          vld
);

    // Pick the requester closest to ptr going upward with wrap-around.
    always_comb begin
        int best_d;
        int d;
        gnt     = '0;
        gnt_idx = '0;
        vld     = 1'b0;
        best_d  = N;
        d       = 0;
        for (int i = 0; i < N; i++) begin
            d = i - int'(ptr);
            if (d < 0) begin
                d = d + N;
            end
            if (req[i] && (d < best_d)) begin
                best_d  = d;
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = PW'(i);
                vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack among N_REQ requesters: round-robin issue of one
// push or pop per cycle, occupancy tracking, and routing of pop data back.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = 16,
    localparam int CW   = count_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_push,
    input  logic [N_REQ-1:0]   req_pop,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [WIDTH-1:0]   stk_data_in,
    input  logic [WIDTH-1:0]   stk_data_out
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] push_elig;
    logic [N_REQ-1:0] pop_elig;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_vld;
    logic [PW-1:0]    rr_ptr;

    op_t              op_p0;
    logic [WIDTH-1:0] data_p0;

    op_t              op_p1;
    logic [N_REQ-1:0] grant_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CW-1:0]    count_p1;

    logic             vld_p2;
    logic [N_REQ-1:0] tag_p2;

    assign full  = (count_p1 == CW'(DEPTH));
    assign empty = (count_p1 == '0);
    assign count = count_p1;

    // A requester asking for both is treated as a push; its pop waits.
    assign push_elig = req_push & {N_REQ{~full}};
    assign pop_elig  = req_pop & ~req_push & {N_REQ{~empty}};

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req     (push_elig | pop_elig),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .vld     (arb_vld)
    );

    // Decode the winner's operation and select its push data.
    always_comb begin
        op_p0   = OP_NONE;
        data_p0 = '0;
        if (arb_vld) begin
            op_p0 = (|(arb_gnt & push_elig)) ? OP_PUSH : OP_POP;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i] && (op_p0 == OP_PUSH)) begin
                data_p0 = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ---- issue stage: grant, stack command, pointer and occupancy ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_p1    <= OP_NONE;
            grant_p1 <= '0;
            data_p1  <= '0;
            count_p1 <= '0;
            rr_ptr   <= '0;
        end else begin
            op_p1    <= op_p0;
            grant_p1 <= arb_gnt;
            data_p1  <= data_p0;
            if (arb_vld) begin
                rr_ptr <= (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + PW'(1);
            end
            case (op_p0)
                OP_PUSH: count_p1 <= count_p1 + CW'(1);
                OP_POP:  count_p1 <= count_p1 - CW'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

    // ---- response stage: tag the pop so its data returns to the issuer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            tag_p2 <= '0;
        end else begin
            vld_p2 <= (op_p1 == OP_POP);
            tag_p2 <= grant_p1;
        end
    end

    assign grant       = grant_p1;
    assign stk_push    = (op_p1 == OP_PUSH);
    assign stk_pop     = (op_p1 == OP_POP);
    assign stk_data_in = data_p1;
    assign rsp_valid   = vld_p2 ? tag_p2 : '0;
    assign rsp_data    = vld_p2 ? stk_data_out : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_stack_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_push = '0;
    logic [N-1:0]   req_pop  = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic           stk_push;
    logic           stk_pop;
    logic [W-1:0]   stk_data_in;
    logic [W-1:0]   stk_data_out = '0;

    stack_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_push     (req_push),
        .req_pop      (req_pop),
        .req_data     (req_data),
        .grant        (grant),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out)
    );

    always #5 clk = ~clk;

    // Stack memory the arbiter drives; read data appears the cycle after a pop.
    logic [W-1:0] smem [D];
    int           sp = 0;
    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < D) begin
            smem[sp] <= stk_data_in;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= smem[sp-1];
            sp <= sp - 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] mq[$];
    int           mptr = 0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_rsp_v = '0;
    logic [W-1:0] e_rsp_d = '0;
    logic         e_push  = 1'b0;
    logic         e_pop   = 1'b0;
    logic [W-1:0] e_din   = '0;
    bit           pend_v  = 0;
    int           pend_tag = 0;
    logic [W-1:0] pend_data = '0;

    task automatic model_reset();
        mq.delete();
        mptr = 0;
        e_grant = '0; e_rsp_v = '0; e_rsp_d = '0;
        e_push = 1'b0; e_pop = 1'b0; e_din = '0;
        pend_v = 0; pend_tag = 0; pend_data = '0;
    endtask

    task automatic model_step();
        int  w;
        int  j;
        bit  is_push;
        int  sz;
        sz = mq.size();
        e_rsp_v = '0;
        if (pend_v) e_rsp_v[pend_tag] = 1'b1;
        e_rsp_d = pend_data;
        pend_v = 0;
        w = -1;
        is_push = 0;
        for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (w < 0) begin
                if (req_push[j] && sz < D) begin
                    w = j; is_push = 1;
                end else if (req_pop[j] && !req_push[j] && sz > 0) begin
                    w = j; is_push = 0;
                end
            end
        end
        e_grant = '0; e_push = 1'b0; e_pop = 1'b0; e_din = '0;
        if (w >= 0) begin
            e_grant[w] = 1'b1;
            mptr = (w + 1) % N;
            if (is_push) begin
                e_push = 1'b1;
                e_din = req_data[w*W +: W];
                mq.push_back(e_din);
            end else begin
                e_pop = 1'b1;
                pend_v = 1;
                pend_tag = w;
                pend_data = mq.pop_back();
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison of DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("grant", 32'(grant), 32'(e_grant));
                check("stk_push", 32'(stk_push), 32'(e_push));
                check("stk_pop", 32'(stk_pop), 32'(e_pop));
                check("stk_data_in", 32'(stk_data_in), 32'(e_din));
                check("rsp_valid", 32'(rsp_valid), 32'(e_rsp_v));
                if (e_rsp_v != '0) check("rsp_data", 32'(rsp_data), 32'(e_rsp_d));
                check("count", 32'(count), 32'(mq.size()));
                check("full", 32'(full), 32'(mq.size() == D));
                check("empty", 32'(empty), 32'(mq.size() == 0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    bit act [N];

    initial begin
        logic [N-1:0] g_prev;
        int r;
        for (int i = 0; i < N; i++) act[i] = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_stk_push", 32'(stk_push), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);

        // 1: single push
        req_push[0] = 1'b1; set_data(0, 8'd7);
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_stk_push", 32'(stk_push), 32'h1);
        check("t1_din", 32'(stk_data_in), 32'd7);
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'h0);
        // 2: push 5, then two pops by requester 1
        set_data(0, 8'd5);
        tick();
        check("t2_din", 32'(stk_data_in), 32'd5);
        req_push[0] = 1'b0;
        req_pop[1] = 1'b1;
        tick();
        check("t2_grant_pop", 32'(grant), 32'h2);
        check("t2_stk_pop", 32'(stk_pop), 32'h1);
        tick();
        check("t2_rsp_valid1", 32'(rsp_valid), 32'h2);
        check("t2_rsp_data1", 32'(rsp_data), 32'd5);
        req_pop[1] = 1'b0;
        tick();
        check("t2_rsp_data2", 32'(rsp_data), 32'd7);
        check("t2_empty", 32'(empty), 32'h1);

        // 3: two continuous pushers fill DEPTH=4 (pointer currently at 2)
        req_push[0] = 1'b1; set_data(0, 8'h10);
        req_push[1] = 1'b1; set_data(1, 8'h11);
        tick(); check("t3_g0", 32'(grant), 32'h1);
        tick(); check("t3_g1", 32'(grant), 32'h2);
        tick(); check("t3_g2", 32'(grant), 32'h1);
        tick(); check("t3_g3", 32'(grant), 32'h2);
        check("t3_full", 32'(full), 32'h1);
        check("t3_count", 32'(count), 32'd4);
        tick();
        check("t3_nopush", 32'(stk_push), 32'h0);
        check("t3_nogrant", 32'(grant), 32'h0);
        req_push = '0;

        // drain with requester 2
        req_pop[2] = 1'b1;
        repeat (4) tick();
        req_pop[2] = 1'b0;
        check("drain_empty", 32'(empty), 32'h1);
        tick();
        check("drain_last_rsp", 32'(rsp_data), 32'h10);

        // 4: pop on empty stalls, push proceeds, then pop
        req_pop[0] = 1'b1;
        tick();
        check("t4_nogrant", 32'(grant), 32'h0);
        check("t4_nopop", 32'(stk_pop), 32'h0);
        req_push[1] = 1'b1; set_data(1, 8'h33);
        tick();
        check("t4_push_grant", 32'(grant), 32'h2);
        req_push[1] = 1'b0;
        tick();
        check("t4_pop_grant", 32'(grant), 32'h1);
        check("t4_stk_pop", 32'(stk_pop), 32'h1);
        req_pop[0] = 1'b0;
        tick();
        check("t4_rsp", 32'(rsp_data), 32'h33);

        // 5: push and pop both high from one requester
        req_push[0] = 1'b1; req_pop[0] = 1'b1; set_data(0, 8'h44);
        tick();
        check("t5_push_first", 32'(stk_push), 32'h1);
        req_push[0] = 1'b0;
        tick();
        check("t5_pop_second", 32'(stk_pop), 32'h1);
        check("t5_pop_grant", 32'(grant), 32'h1);
        req_pop[0] = 1'b0;
        tick();
        check("t5_rsp", 32'(rsp_data), 32'h44);

        // 6: reset during a pop response
        req_push[1] = 1'b1; set_data(1, 8'h55);
        tick();
        set_data(1, 8'h66);
        tick();
        req_push[1] = 1'b0;
        req_pop[0] = 1'b1;
        tick();
        req_pop[0] = 1'b0;
        tick();
        check("t6_rsp_before", 32'(rsp_valid), 32'h1);
        check("t6_rsp_data_before", 32'(rsp_data), 32'h66);
        #1 rst = 1'b1;
        #1;
        check("t6_rsp_valid_rst", 32'(rsp_valid), 32'h0);
        check("t6_rsp_data_rst", 32'(rsp_data), 32'h0);
        check("t6_count_rst", 32'(count), 32'h0);
        check("t6_empty_rst", 32'(empty), 32'h1);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        req_push[2] = 1'b1; set_data(2, 8'h77);
        tick();
        check("t6_resume_grant", 32'(grant), 32'h4);
        check("t6_resume_count", 32'(count), 32'd1);
        req_push[2] = 1'b0;
        tick();

        // randomized traffic, requests held until granted (occasionally dropped)
        for (int c = 0; c < 3000; c++) begin
            g_prev = grant;
            for (int i = 0; i < N; i++) begin
                if (g_prev[i] || !act[i] || $urandom_range(0, 15) == 0) begin
                    r = int'($urandom_range(0, 7));
                    req_push[i] = (r == 3 || r == 4 || r == 7);
                    req_pop[i]  = (r == 5 || r == 6 || r == 7);
                    act[i] = (r >= 3);
                    set_data(i, W'($urandom));
                end
            end
            if (c == 1500) begin
                #1 rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end
            tick();
        end
        req_push = '0;
        req_pop = '0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
